// File: rtl/mux_pkg.sv
// Shared encodings and width helpers for the scanning multiplexer family.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  typedef enum logic {
    SCAN_HOLD = 1'b0,
    SCAN_STEP = 1'b1
  } scan_state_e;

  // Width of a counter/index able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Dwell counter plus round-robin channel counter; advances after DWELL enabled cycles.
// Zero-cycle decode of the step state; en=0 freezes everything, so an expiry is deferred rather than lost.
module scan_counter
  import mux_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int DWELL = 8,
  localparam int SELW  = clog2_min1(NCH),
  localparam int CNTW  = clog2_min1(DWELL) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            load,
  input  logic [SELW-1:0] load_val,
  output logic [SELW-1:0] chan,
  output logic            wrap_pend
);

  localparam logic [CNTW-1:0] LAST_DWELL = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] LAST_CH    = SELW'(NCH - 1);

  logic [CNTW-1:0] dwell_cnt;
  logic [CNTW-1:0] dwell_nxt;
  logic [SELW-1:0] chan_nxt;
  logic            wrap_nxt;
  scan_state_e     state;

  always_comb begin
    state     = (dwell_cnt == LAST_DWELL) ? SCAN_STEP : SCAN_HOLD;
    dwell_nxt = dwell_cnt;
    chan_nxt  = chan;
    wrap_nxt  = wrap_pend;
    if (en) begin
      // wrap_pend marks that channel 0 was reached by wrapping and is shown on the next enabled edge
      wrap_nxt = 1'b0;
      if (load) begin
        dwell_nxt = '0;
        chan_nxt  = load_val;
      end else if (state == SCAN_STEP) begin
        dwell_nxt = '0;
        if (chan == LAST_CH) begin
          chan_nxt = '0;
          wrap_nxt = 1'b1;
        end else begin
          chan_nxt = chan + 1'b1;
        end
      end else begin
        dwell_nxt = dwell_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      chan      <= '0;
      wrap_pend <= 1'b0;
    end else begin
      dwell_cnt <= dwell_nxt;
      chan      <= chan_nxt;
      wrap_pend <= wrap_nxt;
    end
  end

endmodule

// File: rtl/mux_scan_reg.sv
// Registered NCH-channel mux with manual select or auto round-robin scan; 1-cycle din->dout latency.
// No backpressure: en=0 holds data/index/counters and drops valid and wrap.
module mux_scan_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NCH   = 4,
  parameter  int DWELL = 8,
  localparam int SELW  = clog2_min1(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic                 en,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      ch_out,
  output logic                 valid,
  output logic                 wrap,
  output logic                 sel_err
);

  localparam logic [SELW:0] NCH_EXT = (SELW + 1)'(NCH);

  logic [WIDTH-1:0] ch_data [NCH];
  logic             sel_ok;
  logic             load;
  logic [SELW-1:0]  load_val;
  logic [SELW-1:0]  chan;
  logic             wrap_pend;

  for (genvar k = 0; k < NCH; k++) begin : g_unpack
    assign ch_data[k] = din[k*WIDTH +: WIDTH];
  end

  assign sel_ok   = ({1'b0, sel} < NCH_EXT);
  assign load     = (mode == MODE_MANUAL);
  assign load_val = sel_ok ? sel : '0;

  // Manual mode keeps the scan counter parked on the clamped select so auto resumes from there.
  scan_counter #(
    .NCH   (NCH),
    .DWELL (DWELL)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .chan      (chan),
    .wrap_pend (wrap_pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout    <= '0;
      ch_out  <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      valid <= en;
      wrap  <= en && (mode == MODE_AUTO) && wrap_pend;
      if (en) begin
        if (mode == MODE_MANUAL) begin
          sel_err <= !sel_ok;
          if (sel_ok) begin
            dout   <= ch_data[sel];
            ch_out <= sel;
          end else begin
            dout   <= '0;
            ch_out <= '0;
          end
        end else begin
          dout    <= ch_data[chan];
          ch_out  <= chan;
          sel_err <= 1'b0;
        end
      end
    end
  end

endmodule
